mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_copy_dma.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// Single-channel AXI4 memory-to-memory copy engine: reads up to BURST_LEN words
// into a local buffer, writes them out, and repeats until the length is exhausted.
//
// state   | meaning
// IDLE    | waiting for cfg_start
// RD_ADDR | read address issued, waiting for ar_ready
// RD_DATA | collecting read beats into the buffer until r_last
// WR_ADDR | write address issued, waiting for aw_ready
// WR_DATA | streaming buffer out on W
// WR_RESP | waiting for write response, then next burst or finish
// DONE    | raise done_irq, back to IDLE
module mem_copy_dma #(
  parameter int          BURST_LEN = 16,
  parameter logic [3:0]  AXI_ID    = 4'h1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] cfg_src,
  input  logic [31:0] cfg_dst,
  input  logic [15:0] cfg_len,
  input  logic        cfg_start,
  input  logic        irq_clr,
  output logic        busy,
  output logic        done_irq,
  output logic        err,
  output logic [3:0]  aw_id,
  output logic [31:0] aw_addr,
  output logic [7:0]  aw_len,
  output logic [2:0]  aw_size,
  output logic [1:0]  aw_burst,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  output logic        w_last,
  output logic        w_valid,
  input  logic        w_ready,
  input  logic [1:0]  b_resp,
  input  logic        b_valid,
  output logic        b_ready,
  output logic [3:0]  ar_id,
  output logic [31:0] ar_addr,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  output logic        ar_valid,
  input  logic        ar_ready,
  input  logic [31:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  input  logic        r_valid,
  output logic        r_ready
);

  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;

  state_t         state;
  logic [31:0]    src, dst;
  logic [15:0]    remaining;
  logic [BW-1:0]  beats;
  logic [IW-1:0]  idx;
  logic           xfer_err;
  logic [31:0]    buffer [BURST_LEN];

  logic [IW-1:0]  idx_nxt;
  logic [31:0]    src_nxt, dst_nxt;
  logic [15:0]    rem_nxt;

  // Burst size limited by remaining work, buffer depth and both 4 KB pages.
  function automatic logic [BW-1:0] calc_beats(input logic [9:0] s_word,
                                               input logic [9:0] d_word,
                                               input logic [15:0] rem);
    logic [15:0] n, s_room, d_room;
    n      = rem;
    s_room = 16'd1024 - {6'd0, s_word};
    d_room = 16'd1024 - {6'd0, d_word};
    if (n > 16'(BURST_LEN)) n = 16'(BURST_LEN);
    if (n > s_room) n = s_room;
    if (n > d_room) n = d_room;
    return BW'(n);
  endfunction

  assign idx_nxt = idx + 1'b1;
  assign src_nxt = src + (32'(beats) << 2);
  assign dst_nxt = dst + (32'(beats) << 2);
  assign rem_nxt = remaining - 16'(beats);

  assign ar_id    = AXI_ID;
  assign ar_addr  = src;
  assign ar_len   = 8'(beats - BW'(1));
  assign ar_size  = 3'd2;
  assign ar_burst = 2'b01;
  assign aw_id    = AXI_ID;
  assign aw_addr  = dst;
  assign aw_len   = 8'(beats - BW'(1));
  assign aw_size  = 3'd2;
  assign aw_burst = 2'b01;
  assign w_strb   = 4'hF;

  always_ff @(posedge aclk) begin
    if (state == RD_DATA && r_valid && r_ready)
      buffer[idx] <= r_data;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done_irq  <= 1'b0;
      err       <= 1'b0;
      xfer_err  <= 1'b0;
      ar_valid  <= 1'b0;
      r_ready   <= 1'b0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      b_ready   <= 1'b0;
      idx       <= '0;
      remaining <= '0;
      beats     <= '0;
    end else begin
      // Any status set later in this cycle overrides the clear.
      if (irq_clr) begin
        done_irq <= 1'b0;
        err      <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cfg_start) begin
            src       <= cfg_src;
            dst       <= cfg_dst;
            remaining <= cfg_len;
            done_irq  <= 1'b0;
            err       <= 1'b0;
            xfer_err  <= 1'b0;
            idx       <= '0;
            busy      <= 1'b1;
            if (cfg_len == 16'd0) begin
              state <= DONE;
            end else begin
              beats    <= calc_beats(cfg_src[11:2], cfg_dst[11:2], cfg_len);
              ar_valid <= 1'b1;
              state    <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            idx      <= '0;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_valid) begin
            idx <= idx_nxt;
            if (r_resp != 2'b00) begin
              err      <= 1'b1;
              xfer_err <= 1'b1;
            end
            if (r_last) begin
              r_ready  <= 1'b0;
              aw_valid <= 1'b1;
              state    <= WR_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (aw_ready) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b1;
            w_data   <= buffer[0];
            w_last   <= (beats == BW'(1));
            idx      <= '0;
            state    <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_ready) begin
            if (w_last) begin
              w_valid <= 1'b0;
              w_last  <= 1'b0;
              b_ready <= 1'b1;
              state   <= WR_RESP;
            end else begin
              idx    <= idx_nxt;
              w_data <= buffer[idx_nxt];
              w_last <= (BW'(idx_nxt) == beats - BW'(1));
            end
          end
        end
        WR_RESP: begin
          if (b_valid) begin
            b_ready   <= 1'b0;
            src       <= src_nxt;
            dst       <= dst_nxt;
            remaining <= rem_nxt;
            if (b_resp != 2'b00) err <= 1'b1;
            if (xfer_err || b_resp != 2'b00 || rem_nxt == 16'd0) begin
              state <= DONE;
            end else begin
              beats    <= calc_beats(src_nxt[11:2], dst_nxt[11:2], rem_nxt);
              ar_valid <= 1'b1;
              state    <= RD_ADDR;
            end
          end
        end
        DONE: begin
          done_irq <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma: an AXI slave model feeds address-derived read data,
// and a scoreboard of expected AR/AW bursts and W words is checked as the DUT emits them.
module tb_mem_copy_dma;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        cfg_start, irq_clr;
  logic        busy, done_irq, err;
  logic [3:0]  aw_id, ar_id;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic [3:0]  w_strb;

  always #5 aclk = ~aclk;

  mem_copy_dma #(.BURST_LEN(16), .AXI_ID(4'h1)) dut (
    .aclk(aclk), .areset(areset),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_start(cfg_start), .irq_clr(irq_clr),
    .busy(busy), .done_irq(done_irq), .err(err),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready)
  );

  int errors = 0;
  int checks = 0;

  logic [39:0] exp_ar[$];
  logic [39:0] exp_aw[$];
  logic [31:0] exp_w[$];

  bit          stall_en = 1'b0;
  int          err_beat = -1;
  int          rbeat    = 0;
  int          rd_left, wr_left;
  logic [31:0] rd_addr;
  bit          b_pend, r_hs, b_hs, ar_wait, aw_wait;
  logic [39:0] ar_saved, aw_saved;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit stall();
    return stall_en && ($urandom_range(0, 3) == 0);
  endfunction

  // Reference split of a copy into bursts: min(remaining, 16, room in src page, room in dst page).
  task automatic push_expect(input int src, input int dst, input int len, input bit first_only);
    int s, d, r, b, sr, dr;
    s = src; d = dst; r = len;
    while (r > 0) begin
      b  = (r > 16) ? 16 : r;
      sr = (4096 - (s % 4096)) / 4;
      dr = (4096 - (d % 4096)) / 4;
      if (b > sr) b = sr;
      if (b > dr) b = dr;
      exp_ar.push_back({32'(s), 8'(b - 1)});
      exp_aw.push_back({32'(d), 8'(b - 1)});
      for (int i = 0; i < b; i++) exp_w.push_back(rdata(32'(s + 4 * i)));
      s += 4 * b; d += 4 * b; r -= b;
      if (first_only) break;
    end
  endtask

  // AXI slave: every decision is made at the falling edge for the following rising edge.
  always @(negedge aclk) begin
    if (areset) begin
      ar_ready = 0; aw_ready = 0; w_ready = 0;
      r_valid = 0; r_last = 0; r_resp = 0; r_data = 0;
      b_valid = 0; b_resp = 0;
      rd_left = 0; wr_left = 0; b_pend = 0; r_hs = 0; b_hs = 0;
      ar_wait = 0; aw_wait = 0;
    end else begin
      if (b_hs) begin b_valid = 0; b_hs = 0; end
      if (!b_valid && b_pend && !stall()) begin b_valid = 1; b_resp = 2'b00; b_pend = 0; end
      if (b_valid && b_ready) b_hs = 1;

      if (r_hs) begin r_valid = 0; r_hs = 0; end
      if (!r_valid && rd_left > 0 && !stall()) begin
        r_valid = 1;
        r_data  = rdata(rd_addr);
        r_last  = (rd_left == 1);
        r_resp  = (rbeat == err_beat) ? 2'b10 : 2'b00;
      end
      if (r_valid && r_ready) begin r_hs = 1; rd_addr += 4; rd_left--; rbeat++; end

      ar_ready = !stall();
      if (ar_valid) begin
        if (ar_wait) chk("ar_stable", {ar_addr, ar_len}, ar_saved);
        if (ar_ready) begin
          chk("ar_expected", 40'(exp_ar.size() != 0), 40'd1);
          if (exp_ar.size() != 0) chk("ar_burst", {ar_addr, ar_len}, exp_ar.pop_front());
          chk("ar_attr", 40'({ar_id, ar_size, ar_burst}), 40'({4'h1, 3'd2, 2'b01}));
          chk("ar_while_write", 40'(wr_left != 0 || b_pend || b_valid), 40'd0);
          rd_addr = ar_addr; rd_left = int'(ar_len) + 1; ar_wait = 0;
        end else begin
          ar_wait = 1; ar_saved = {ar_addr, ar_len};
        end
      end

      aw_ready = !stall();
      if (aw_valid) begin
        if (aw_wait) chk("aw_stable", {aw_addr, aw_len}, aw_saved);
        if (aw_ready) begin
          chk("aw_expected", 40'(exp_aw.size() != 0), 40'd1);
          if (exp_aw.size() != 0) chk("aw_burst", {aw_addr, aw_len}, exp_aw.pop_front());
          chk("aw_attr", 40'({aw_id, aw_size, aw_burst}), 40'({4'h1, 3'd2, 2'b01}));
          chk("aw_while_read", 40'(rd_left), 40'd0);
          wr_left = int'(aw_len) + 1; aw_wait = 0;
        end else begin
          aw_wait = 1; aw_saved = {aw_addr, aw_len};
        end
      end

      w_ready = !stall();
      if (w_valid && w_ready) begin
        chk("w_expected", 40'(exp_w.size() != 0 && wr_left > 0), 40'd1);
        if (exp_w.size() != 0) chk("w_data", 40'(w_data), 40'(exp_w.pop_front()));
        chk("w_last", 40'({w_last, w_strb}), 40'({wr_left == 1, 4'hF}));
        wr_left--;
        if (wr_left == 0) b_pend = 1;
      end
    end
  end

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    cfg_src = s; cfg_dst = d; cfg_len = n; cfg_start = 1;
    @(negedge aclk);
    cfg_start = 0;
  endtask

  task automatic finish_test(input string tag, input logic exp_err);
    int n = 0;
    while (!done_irq && n < 4000) begin @(negedge aclk); n++; end
    chk({tag, "_done"}, 40'(done_irq), 40'd1);
    chk({tag, "_busy"}, 40'(busy), 40'd0);
    chk({tag, "_err"}, 40'(err), 40'(exp_err));
    chk({tag, "_drained"}, 40'(exp_ar.size() + exp_aw.size() + exp_w.size()), 40'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset = 1; cfg_src = 0; cfg_dst = 0; cfg_len = 0; cfg_start = 0; irq_clr = 0;
    repeat (3) @(negedge aclk);
    areset = 0;
    @(negedge aclk);
    chk("reset_state", 40'({busy, done_irq, err, ar_valid, aw_valid, w_valid, r_ready, b_ready}), 40'd0);

    // Single short burst.
    push_expect(32'h1000, 32'h2000, 5, 0);
    start(32'h1000, 32'h2000, 16'd5);
    chk("t1_busy_after_start", 40'(busy), 40'd1);
    finish_test("t1", 1'b0);

    irq_clr = 1; @(negedge aclk); irq_clr = 0;
    chk("irq_clr", 40'({done_irq, err}), 40'd0);

    // 40 words -> 16,16,8 at 0x1000,0x1040,0x1080.
    push_expect(32'h1000, 32'h3000, 40, 0);
    start(32'h1000, 32'h3000, 16'd40);
    finish_test("t40", 1'b0);

    // Source straddles a 4 KB page.
    push_expect(32'h0FF8, 32'h2000, 4, 0);
    start(32'h0FF8, 32'h2000, 16'd4);
    finish_test("t4k", 1'b0);

    // Zero length: DONE next cycle, done_irq visible two cycles after the start pulse.
    start(32'h4000, 32'h5000, 16'd0);
    chk("len0_cycle1", 40'({done_irq, busy}), 40'b01);
    @(negedge aclk);
    chk("len0_cycle2", 40'({done_irq, busy}), 40'b10);

    // irq_clr coinciding with DONE loses to the set.
    start(32'h4000, 32'h5000, 16'd0);
    irq_clr = 1; @(negedge aclk); irq_clr = 0;
    chk("clr_vs_done", 40'(done_irq), 40'd1);
    irq_clr = 1; @(negedge aclk); irq_clr = 0;
    chk("clr_after_done", 40'(done_irq), 40'd0);

    // Read error on the third beat of an 8-beat burst; no further bursts.
    err_beat = rbeat + 2;
    push_expect(32'h0FE0, 32'h6000, 20, 1);
    start(32'h0FE0, 32'h6000, 16'd20);
    finish_test("terr", 1'b1);
    err_beat = -1;

    // Random stalls, destination page split, and an ignored second start while busy.
    stall_en = 1;
    push_expect(32'h2010, 32'h7FC0, 37, 0);
    start(32'h2010, 32'h7FC0, 16'd37);
    chk("err_cleared_by_start", 40'({err, done_irq}), 40'd0);
    repeat (5) @(negedge aclk);
    chk("busy_before_restart", 40'(busy), 40'd1);
    start(32'h9000, 32'hA000, 16'd3);
    finish_test("tstall", 1'b0);
    stall_en = 0;

    repeat (4) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
